// File: rtl/parking_pkg.sv
// Shared definitions for the car-park occupancy counter: the capacity ceiling,
// the BCD digit type and the encoding of entry/exit events.
package parking_pkg;

    localparam int PARK_CAPACITY_MAX = 99;

    typedef logic [3:0] bcd_digit_t;

    // The encoding is the concatenation {inc_ev, dec_ev}.
    typedef enum logic [1:0] {
        EV_NONE = 2'b00,
        EV_OUT  = 2'b01,
        EV_IN   = 2'b10,
        EV_BOTH = 2'b11
    } park_event_e;

    function automatic park_event_e decode_event(input logic inc_ev, input logic dec_ev);
        return park_event_e'({inc_ev, dec_ev});
    endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One decimal digit that counts up or down in step with the binary count.
// carry/borrow flag the 9->0 and 0->9 transitions for the next digit up.
module bcd_digit_updown
    import parking_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       up,
    input  logic       down,
    output bcd_digit_t q,
    output logic       carry,
    output logic       borrow
);

    assign carry  = up   & (q == 4'd9);
    assign borrow = down & (q == 4'd0);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (up) begin
            q <= carry ? 4'd0 : q + 4'd1;
        end else if (down) begin
            q <= borrow ? 4'd9 : q - 4'd1;
        end
    end

endmodule

// File: rtl/parking_occupancy_counter.sv
// Counts parked cars from edge-detected entry/exit events, saturating at 0 and
// CAPACITY, with a lockstep BCD mirror, full/empty decodes and sticky error flags.
module parking_occupancy_counter
    import parking_pkg::*;
#(
    parameter int CAPACITY = 99,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output bcd_digit_t       bcd_tens,
    output bcd_digit_t       bcd_ones,
    output logic             full,
    output logic             empty,
    output logic             err_over,
    output logic             err_under
);

    if (CAPACITY < 1 || CAPACITY > PARK_CAPACITY_MAX || CAPACITY >= (1 << CNT_W)) begin : g_bad_capacity
        $error("parking_occupancy_counter: CAPACITY %0d illegal for CNT_W %0d", CAPACITY, CNT_W);
    end

    localparam logic [CNT_W-1:0] CAP_COUNT = CNT_W'(CAPACITY);

    logic        inc_q;
    logic        dec_q;
    logic        do_inc;
    logic        do_dec;
    logic        ones_carry;
    logic        ones_borrow;
    logic        tens_carry;
    logic        tens_borrow;
    park_event_e ev;

    assign ev    = decode_event(inc & ~inc_q, dec & ~dec_q);
    assign full  = (count == CAP_COUNT);
    assign empty = (count == '0);

    // A simultaneous in/out (EV_BOTH) nets to zero and never moves the count.
    assign do_inc = ~clr & (ev == EV_IN)  & ~full;
    assign do_dec = ~clr & (ev == EV_OUT) & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            count     <= '0;
            err_over  <= 1'b0;
            err_under <= 1'b0;
        end else begin
            inc_q <= inc;
            dec_q <= dec;
            if (clr) begin
                count     <= '0;
                err_over  <= 1'b0;
                err_under <= 1'b0;
            end else begin
                if (do_inc) begin
                    count <= count + CNT_W'(1);
                end else if (do_dec) begin
                    count <= count - CNT_W'(1);
                end
                if (ev == EV_IN && full) begin
                    err_over <= 1'b1;
                end
                if (ev == EV_OUT && empty) begin
                    err_under <= 1'b1;
                end
            end
        end
    end

    bcd_digit_updown u_ones (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .up     (do_inc),
        .down   (do_dec),
        .q      (bcd_ones),
        .carry  (ones_carry),
        .borrow (ones_borrow)
    );

    bcd_digit_updown u_tens (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .up     (ones_carry),
        .down   (ones_borrow),
        .q      (bcd_tens),
        .carry  (tens_carry),
        .borrow (tens_borrow)
    );

    // Saturation keeps the count within 0..99, so the tens digit never rolls.
    a_tens_no_roll : assert property (@(posedge clk) disable iff (!rst_n)
        !(tens_carry || tens_borrow));

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Directed bench: a CAPACITY=10 instance driven from a vector table and a
// CAPACITY=99 instance driven by hand-written multi-cycle sequences.
module tb_parking_occupancy_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc99 = 1'b0, dec99 = 1'b0, clr99 = 1'b0;
    logic       inc10 = 1'b0, dec10 = 1'b0, clr10 = 1'b0;
    logic [6:0] count99, count10;
    logic [3:0] tens99, ones99, tens10, ones10;
    logic       full99, empty99, over99, under99;
    logic       full10, empty10, over10, under10;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    parking_occupancy_counter #(.CAPACITY(99), .CNT_W(7)) dut99 (
        .clk(clk), .rst_n(rst_n), .inc(inc99), .dec(dec99), .clr(clr99),
        .count(count99), .bcd_tens(tens99), .bcd_ones(ones99),
        .full(full99), .empty(empty99), .err_over(over99), .err_under(under99)
    );

    parking_occupancy_counter #(.CAPACITY(10), .CNT_W(7)) dut10 (
        .clk(clk), .rst_n(rst_n), .inc(inc10), .dec(dec10), .clr(clr10),
        .count(count10), .bcd_tens(tens10), .bcd_ones(ones10),
        .full(full10), .empty(empty10), .err_over(over10), .err_under(under10)
    );

    typedef struct {
        logic inc;
        logic dec;
        logic clr;
        int   cnt;
        logic over;
        logic under;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Digits, full and empty are derived from the expected count by arithmetic.
    task automatic check_state(input string tag, input bit sel10, input int cnt,
                               input bit over, input bit under);
        int cap;
        int a_cnt, a_tens, a_ones, a_full, a_empty, a_over, a_under;
        cap = sel10 ? 10 : 99;
        if (sel10) begin
            a_cnt = int'(count10); a_tens = int'(tens10); a_ones = int'(ones10);
            a_full = int'(full10); a_empty = int'(empty10);
            a_over = int'(over10); a_under = int'(under10);
        end else begin
            a_cnt = int'(count99); a_tens = int'(tens99); a_ones = int'(ones99);
            a_full = int'(full99); a_empty = int'(empty99);
            a_over = int'(over99); a_under = int'(under99);
        end
        check({tag, " count"},     a_cnt,   cnt);
        check({tag, " tens"},      a_tens,  cnt / 10);
        check({tag, " ones"},      a_ones,  cnt % 10);
        check({tag, " full"},      a_full,  int'(cnt == cap));
        check({tag, " empty"},     a_empty, int'(cnt == 0));
        check({tag, " err_over"},  a_over,  int'(over));
        check({tag, " err_under"}, a_under, int'(under));
    endtask

    task automatic step(input logic i99, input logic d99, input logic c99,
                        input logic i10, input logic d10, input logic c10);
        @(negedge clk);
        inc99 = i99; dec99 = d99; clr99 = c99;
        inc10 = i10; dec10 = d10; clr10 = c10;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse99(input logic i, input logic d, input int n);
        for (int k = 0; k < n; k++) begin
            step(i, d, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    function automatic vec_t mk(input logic i, input logic d, input logic c,
                                input int cnt, input logic o, input logic u);
        vec_t v;
        v.inc = i; v.dec = d; v.clr = c; v.cnt = cnt; v.over = o; v.under = u;
        return v;
    endfunction

    initial begin
        // Vector table for the CAPACITY=10 instance, one row per clock.
        vecs.push_back(mk(0, 1, 0, 0, 0, 1));   // exit while empty
        vecs.push_back(mk(0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0));   // clr drops the error
        vecs.push_back(mk(1, 1, 0, 0, 0, 0));   // both at empty: no error
        vecs.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            vecs.push_back(mk(1, 0, 0, k, 0, 0));
            vecs.push_back(mk(0, 0, 0, k, 0, 0));
        end
        vecs.push_back(mk(1, 1, 0, 10, 0, 0));  // both at full: no error
        vecs.push_back(mk(0, 0, 0, 10, 0, 0));
        vecs.push_back(mk(1, 0, 0, 10, 1, 0));  // eleventh entry overflows
        vecs.push_back(mk(0, 0, 0, 10, 1, 0));
        vecs.push_back(mk(0, 1, 0, 9, 1, 0));   // borrow 10 -> 9, error sticky
        vecs.push_back(mk(0, 0, 0, 9, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0));   // clr

        repeat (3) @(posedge clk);
        #1;
        check_state("reset99", 1'b0, 0, 1'b0, 1'b0);
        check_state("reset10", 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(1'b0, 1'b0, 1'b0, vecs[i].inc, vecs[i].dec, vecs[i].clr);
            check_state($sformatf("vec%0d", i), 1'b1, vecs[i].cnt, vecs[i].over, vecs[i].under);
        end

        pulse99(1'b1, 1'b0, 12);
        check_state("twelve_pulses", 1'b0, 12, 1'b0, 1'b0);

        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("held_inc", 1'b0, 13, 1'b0, 1'b0);

        pulse99(1'b0, 1'b1, 8);
        check_state("down_to_5", 1'b0, 5, 1'b0, 1'b0);
        pulse99(1'b1, 1'b1, 1);
        check_state("both_at_5", 1'b0, 5, 1'b0, 1'b0);

        pulse99(1'b0, 1'b1, 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_state("clr_with_inc", 1'b0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("clr_no_late_inc", 1'b0, 0, 1'b0, 1'b0);

        pulse99(1'b1, 1'b0, 10);
        pulse99(1'b0, 1'b1, 1);
        check_state("borrow_10_to_9", 1'b0, 9, 1'b0, 1'b0);

        pulse99(1'b1, 1'b0, 28);
        check_state("at_37", 1'b0, 37, 1'b0, 1'b0);

        // Asynchronous reset: outputs must clear before the next rising edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_reset", 1'b0, 0, 1'b0, 1'b0);

        // An input already high at release counts on the first edge.
        inc99 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("inc_at_release", 1'b0, 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        pulse99(1'b1, 1'b0, 98);
        check_state("full_99", 1'b0, 99, 1'b0, 1'b0);
        pulse99(1'b1, 1'b0, 1);
        check_state("over_99", 1'b0, 99, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/parking_occupancy_counter.md
# parking_occupancy_counter

Occupancy tracker for the car-park controller: consumes the single-cycle "car entered" (`inc`) and "car left" (`dec`) event pulses from the entry/exit direction-detecting FSM. It maintains the number of parked cars and mirrors that count in two BCD digits for the seven-segment display. It drives `full`/`empty` status and sticky error flags for impossible events: entry when full, exit when empty. It is the receiving end of the S/R event interface.

## Interface
- `CAPACITY`, 99: number of spaces; legal range 1..99.
- `CNT_W`, 7: width of binary count; must hold `CAPACITY`.

- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `inc` in 1: car-entered event (S from the direction FSM); level input, edge-detected.
- `dec` in 1: car-left event (R from the direction FSM); level input, edge-detected.
- `clr` in 1: synchronous clear of count and error flags.
- `count` out `CNT_W`: cars currently parked, binary.
- `bcd_tens` out 4: tens digit of `count`.
- `bcd_ones` out 4: ones digit of `count`.
- `full` out 1: `count == CAPACITY`.
- `empty` out 1: `count == 0`.
- `err_over` out 1: sticky; an entry event arrived while full.
- `err_under` out 1: sticky; an exit event arrived while empty.

## Operation
- **Edge detection:** `inc_q`/`dec_q` register previous input levels.
  - Event `inc_ev = inc & ~inc_q`; `dec_ev = dec & ~dec_q`.
  - A level held N cycles counts once.
- **Update rule, evaluated each edge, priority top-down:**
  - `clr`: count=0, BCD=0/0, both error flags cleared; events that cycle are discarded.
  - `inc_ev & dec_ev`: net zero, count unchanged, no error (one in, one out). This applies even when full or empty.
  - `inc_ev` only:
    - if count < `CAPACITY`, count+1;
    - else count holds and `err_over` is set.
  - `dec_ev` only:
    - if count > 0, count−1;
    - else count holds and `err_under` is set.
- **Arithmetic:** count never wraps; saturates at 0 and `CAPACITY`.
- **BCD counters:** updated in lockstep with the binary count, never derived by division.
  - Increment: ones 9→0 with carry into tens.
  - Decrement: ones 0→9 with borrow from tens.
  - Invariant: `10*bcd_tens + bcd_ones == count` every cycle.
- **Error flags:** stay set until `clr` or reset.
- **Status flags:** `full`/`empty` are combinational decodes of the registered count.

## Timing
- **Reset values** (async on `rst_n` low, held until release):
  - count=0, bcd_tens=0, bcd_ones=0;
  - empty=1, full=0;
  - err_over=0, err_under=0;
  - inc_q=0, dec_q=0.
- **Reset mid-operation:** all outputs go to reset values immediately, without waiting for a clock edge. Any event in progress is lost.
- **Latency:** an `inc`/`dec` rising level sampled at edge k produces the new `count`/BCD/flags after edge k (visible in cycle k+1).
- **Minimum event spacing:** one cycle low between events on the same input.
- **Input after reset release:** an input already high when `rst_n` releases counts as an event at the first edge, because `inc_q`/`dec_q` reset to 0.
- **Timing domain:** `inc`/`dec` come from logic on the same `clk`; no synchroniser is required.

## Structure
- **Shared package `parking_pkg`:**
  - `PARK_CAPACITY_MAX = 99`;
  - BCD digit typedef (4-bit);
  - event encoding enum `{EV_NONE, EV_IN, EV_OUT, EV_BOTH}` built from `{inc_ev, dec_ev}`.
- **Sub-module `bcd_digit_updown`:**
  - ports: `clk`, `rst_n`, `clr`, `up`, `down`, `q[3:0]`, `carry`, `borrow`;
  - instantiated twice, the ones digit's carry/borrow feeding the tens digit's up/down.
- **Elaboration check:** reject `CAPACITY` outside 1..99 or not representable in `CNT_W`.

## Test plan
- **Reset:**
  - Stimulus: hold `rst_n`=0, then release.
  - Required: count=0, tens/ones=0/0, empty=1, full=0, errors=0.
  - Stimulus: drop `rst_n` asynchronously at count=37.
  - Required: outputs read 0 before the next edge.
- **Counting and edge detection:**
  - Stimulus: 12 single-cycle `inc` pulses.
  - Required: count=12, tens=1, ones=2.
  - Stimulus: then `inc` held high 5 cycles.
  - Required: count=13 (only one event counted).
- **Overflow (`CAPACITY`=10):**
  - Stimulus: 11 `inc` pulses.
  - Required: count=10, full=1, err_over=1.
  - Stimulus: then `clr`.
  - Required: count=0, err_over=0.
- **Underflow and borrow:**
  - Stimulus: `dec` pulse at count=0.
  - Required: count=0, err_under=1.
  - Stimulus: from count=10, one `dec` pulse.
  - Required: count=9, tens=0, ones=9.
- **Simultaneous events:**
  - Stimulus: `inc` and `dec` rise on the same edge at count=5.
  - Required: count stays 5.
  - Stimulus: same at count=`CAPACITY`.
  - Required: count unchanged, err_over stays 0.
- **Clear priority:**
  - Stimulus: `clr` asserted on the same edge as an `inc` rise at count=4.
  - Required: count=0, and no increment appears on later cycles.
